map_port_arbiter: RTL and testbench

MAP_PORT_ARBITER -- requirements
Module: map_port_arbiter

---
 rtl/map_port_arbiter.sv | 117 +++++++++++
 tb/tb_map_port_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/map_port_arbiter.sv
// Round-robin arbiter that shares one BRAM read port between the tank (0) and train (1) requesters.
// Each access walks IDLE -> ISSUE -> WAIT x RD_LAT -> RESP; every output comes straight from a register.
module map_port_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 2,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       gcnt0,
  output logic [15:0]       gcnt1,
  input  logic              cnt_clr
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] WAIT_INIT = 3'(RD_LAT - 1);

  state_t     state;
  logic       last;
  logic       sel;
  logic       pick;
  logic [2:0] wcnt;

  // Requester 1 wins when it is alone, or on a tie when requester 0 was served last.
  always_comb begin
    pick = 1'b0;
    if (req0 && req1) pick = ~last;
    else              pick = req1;
  end

  // The pointer moves when the grant is issued, so an access abandoned by its
  // requester still counts as that requester's turn.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      last     <= 1'b1;
      sel      <= 1'b0;
      wcnt     <= '0;
      mem_en   <= 1'b0;
      mem_addr <= '0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      mem_en  <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state    <= ISSUE;
            sel      <= pick;
            last     <= pick;
            mem_en   <= 1'b1;
            mem_addr <= pick ? addr1 : addr0;
            gnt0     <= ~pick;
            gnt1     <= pick;
          end
        end
        ISSUE: begin
          state <= WAIT;
          wcnt  <= WAIT_INIT;
        end
        WAIT: begin
          if (wcnt == 3'd0) begin
            state <= RESP;
            if (sel) begin
              rdata1  <= mem_rdata;
              rvalid1 <= 1'b1;
            end else begin
              rdata0  <= mem_rdata;
              rvalid0 <= 1'b1;
            end
          end else begin
            wcnt <= wcnt - 3'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating grant counters; a clear beats an increment on the same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gcnt0 <= '0;
      gcnt1 <= '0;
    end else if (cnt_clr) begin
      gcnt0 <= '0;
      gcnt1 <= '0;
    end else begin
      if (gnt0 && gcnt0 != 16'hFFFF) gcnt0 <= gcnt0 + 16'd1;
      if (gnt1 && gcnt1 != 16'hFFFF) gcnt1 <= gcnt1 + 16'd1;
    end
  end

endmodule

// File: tb/tb_map_port_arbiter.sv
// Bench for map_port_arbiter: one instance at RD_LAT=1 driven by directed and random accesses
// checked against a round-robin model, plus an RD_LAT=3 instance for the latency sweep.
module tb_map_port_arbiter;

  localparam int AW  = 14;
  localparam int DW  = 2;
  localparam int LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic          req0, req1, cnt_clr;
  logic [AW-1:0] addr0, addr1;
  logic          gnt0, gnt1, rvalid0, rvalid1, mem_en;
  logic [DW-1:0] rdata0, rdata1, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [15:0]   gcnt0, gcnt1;

  logic          req0_b, req1_b, cnt_clr_b;
  logic [AW-1:0] addr0_b, addr1_b;
  logic          gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, mem_en_b;
  logic [DW-1:0] rdata0_b, rdata1_b, mem_rdata_b;
  logic [AW-1:0] mem_addr_b;
  logic [15:0]   gcnt0_b, gcnt1_b;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] bram_q;
  logic [DW-1:0] pipe3 [3];

  // BRAM models: one-cycle and three-cycle read pipelines over the same contents.
  always @(posedge clk) if (mem_en) bram_q <= mem[mem_addr];
  assign mem_rdata = bram_q;

  always @(posedge clk) begin
    if (mem_en_b) pipe3[0] <= mem[mem_addr_b];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign mem_rdata_b = pipe3[2];

  map_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
    .clk(clk), .rstn(rstn), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .gcnt0(gcnt0), .gcnt1(gcnt1), .cnt_clr(cnt_clr));

  map_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut3 (
    .clk(clk), .rstn(rstn), .req0(req0_b), .req1(req1_b), .addr0(addr0_b), .addr1(addr1_b),
    .gnt0(gnt0_b), .gnt1(gnt1_b), .rvalid0(rvalid0_b), .rvalid1(rvalid1_b),
    .rdata0(rdata0_b), .rdata1(rdata1_b), .mem_en(mem_en_b), .mem_addr(mem_addr_b),
    .mem_rdata(mem_rdata_b), .gcnt0(gcnt0_b), .gcnt1(gcnt1_b), .cnt_clr(cnt_clr_b));

  int total = 0;
  int bad   = 0;
  int last_m;
  int cnt_m [2];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_ctl"}, {27'd0, gnt0, gnt1, rvalid0, rvalid1, mem_en}, 32'd0);
    checkOutput({tag, "_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, "_rdata"}, {28'd0, rdata0, rdata1}, 32'd0);
    checkOutput({tag, "_cnt"}, {gcnt0, gcnt1}, 32'd0);
  endtask

  // One complete access starting at a negedge in an IDLE cycle and ending at the negedge
  // of the following IDLE cycle. The model decides the winner from the round-robin rule.
  task automatic applyStimulus(input bit r0, input bit r1, input logic [AW-1:0] a0,
                               input logic [AW-1:0] a1, input bit drop_early,
                               input bit clr_at_gnt, input bit keep);
    int w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    addr0 = a0;
    addr1 = a1;
    req0  = r0;
    req1  = r1;
    if (r0 && r1) w = (last_m == 0) ? 1 : 0;
    else          w = r1 ? 1 : 0;
    last_m = w;
    a = (w == 1) ? a1 : a0;
    d = mem[a];
    for (int k = 1; k <= LAT + 3; k++) begin
      @(negedge clk);
      checkOutput("gnt0", 32'(gnt0), 32'(k == 1 && w == 0));
      checkOutput("gnt1", 32'(gnt1), 32'(k == 1 && w == 1));
      checkOutput("rvalid0", 32'(rvalid0), 32'(k == LAT + 2 && w == 0));
      checkOutput("rvalid1", 32'(rvalid1), 32'(k == LAT + 2 && w == 1));
      checkOutput("mem_en", 32'(mem_en), 32'(k == 1));
      checkOutput("mem_addr", 32'(mem_addr), 32'(a));
      if (k == LAT + 2)
        checkOutput("rdata", 32'((w == 1) ? rdata1 : rdata0), 32'(d));
      if (k == 1) begin
        if (clr_at_gnt) begin
          cnt_clr  = 1'b1;
          cnt_m[0] = 0;
          cnt_m[1] = 0;
        end else if (cnt_m[w] < 16'hFFFF) begin
          cnt_m[w]++;
        end
      end
      if (k == 2) cnt_clr = 1'b0;
      if ((k == 2 && drop_early) || (k == LAT + 2 && !keep)) begin
        if (w == 1) req1 = 1'b0;
        else        req0 = 1'b0;
      end
    end
    checkOutput("gcnt0", 32'(gcnt0), 32'(cnt_m[0]));
    checkOutput("gcnt1", 32'(gcnt1), 32'(cnt_m[1]));
  endtask

  task automatic resetModel();
    last_m   = 1;
    cnt_m[0] = 0;
    cnt_m[1] = 0;
  endtask

  initial begin
    logic [AW-1:0] ra0, ra1;
    bit rr0, rr1;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    rstn = 1'b0;
    req0 = 0; req1 = 0; cnt_clr = 0; addr0 = '0; addr1 = '0;
    req0_b = 0; req1_b = 0; cnt_clr_b = 0; addr0_b = '0; addr1_b = '0;
    resetModel();

    // Reset state, then release between edges so the first arbitration follows a high edge.
    @(negedge clk);
    checkIdleZero("reset");
    @(negedge clk);
    rstn = 1'b1;

    // Single access from requester 0 with a known pixel.
    mem[14'h0123] = 2'b10;
    applyStimulus(1, 0, 14'h0123, '0, 0, 0, 0);

    // Contention from a fresh reset: 0,1,0,1 with both requests held throughout.
    rstn = 1'b0;
    #1 resetModel();
    @(negedge clk);
    rstn = 1'b1;
    ra0 = AW'($urandom);
    ra1 = AW'($urandom);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, ra0, ra1, 0, 0, 1);
    checkOutput("contend_cnt", {gcnt0, gcnt1}, {16'd2, 16'd2});
    req0 = 0;
    req1 = 0;
    @(negedge clk);

    // Randomized mix of lone and contending requests, some abandoned mid-access.
    for (int i = 0; i < 24; i++) begin
      rr0 = 1'($urandom);
      rr1 = 1'($urandom);
      if (!rr0 && !rr1) rr0 = 1'b1;
      applyStimulus(rr0, rr1, AW'($urandom), AW'($urandom), 1'($urandom_range(0, 3) == 0), 0, 0);
      req0 = 0;
      req1 = 0;
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    // Abandoned access still responds, then the waiting train is served.
    applyStimulus(0, 1, AW'($urandom), AW'($urandom), 0, 0, 0);
    applyStimulus(1, 1, AW'($urandom), addr1, 1, 0, 0);
    applyStimulus(0, 1, addr0, addr1, 0, 0, 0);
    req1 = 0;

    // Clear alone, then clear coincident with a grant.
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    cnt_m[0] = 0;
    cnt_m[1] = 0;
    checkOutput("clr_only", {gcnt0, gcnt1}, 32'd0);
    applyStimulus(1, 0, AW'($urandom), '0, 0, 1, 0);

    // Saturation: preload near the top, then two more grants.
    force dut.gcnt0 = 16'hFFFE;
    #1 release dut.gcnt0;
    cnt_m[0] = 16'hFFFE;
    applyStimulus(1, 0, AW'($urandom), '0, 0, 0, 0);
    checkOutput("sat_reach", 32'(gcnt0), 32'hFFFF);
    applyStimulus(1, 0, AW'($urandom), '0, 0, 0, 0);
    checkOutput("sat_hold", 32'(gcnt0), 32'hFFFF);

    // Reset while waiting on memory: outputs drop at once and no response follows.
    addr0 = AW'($urandom);
    req0  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1 checkIdleZero("rst_wait");
    resetModel();
    req0 = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("post_rst_quiet", {28'd0, gnt0, gnt1, rvalid0, rvalid1}, 32'd0);
    end
    applyStimulus(1, 1, AW'($urandom), AW'($urandom), 0, 0, 0);
    req1 = 0;

    // Latency sweep on the RD_LAT=3 instance.
    addr1_b = AW'($urandom);
    req1_b  = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checkOutput("lat3_gnt1", 32'(gnt1_b), 32'(k == 1));
      checkOutput("lat3_rvalid1", 32'(rvalid1_b), 32'(k == 5));
      checkOutput("lat3_side0", {30'd0, gnt0_b, rvalid0_b}, 32'd0);
      if (k == 5) begin
        checkOutput("lat3_rdata1", 32'(rdata1_b), 32'(mem[addr1_b]));
        req1_b = 1'b0;
      end
    end
    checkOutput("lat3_gcnt1", 32'(gcnt1_b), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
